// File: rtl/comparador_serial_izq_der_if.sv
// comparador_serial_izq_der_if: start/busy/done handshake, operands and results of the serial comparator
interface comparador_serial_izq_der_if #(parameter int N = 8);
    logic         start;
    logic         Pinit;
    logic         Qinit;
    logic [N-2:0] A_resto;
    logic [N-2:0] B_resto;
    logic         busy;
    logic         done;
    logic         mayor;
    logic         menor;
    logic         igual;
    logic         P;
    logic         Q;
    modport master (
        output start, Pinit, Qinit, A_resto, B_resto,
        input  busy, done, mayor, menor, igual, P, Q
    );
    modport slave (
        input  start, Pinit, Qinit, A_resto, B_resto,
        output busy, done, mayor, menor, igual, P, Q
    );
endinterface

// File: rtl/comparador_serial_izq_der.sv
// comparador_serial_izq_der: MSB-first serial A/B compare seeded by the initial cell; COMPARADOR_SALIDA_TEMPRANA_EN enables early exit
module comparador_serial_izq_der #(
    parameter int N = 8
) (
    input logic                          clk,
    input logic                          rst,
    comparador_serial_izq_der_if.slave   bus
);
`ifdef COMPARADOR_SALIDA_TEMPRANA_EN
    localparam bit TEMPRANA = 1'b1;
`else
    localparam bit TEMPRANA = 1'b0;
`endif
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, COMPARA, FIN} state_t;
    state_t        state_q, state_d;
    logic [N-2:0]  a_q, a_d, b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          p_q, p_d, q_q, q_d;
    logic          mayor_q, mayor_d, menor_q, menor_d, igual_q, igual_d;
    logic          p_n, q_n, ultimo;
    always_comb begin
        // 10 and 01 are absorbing; only the equal state looks at the current bit pair
        p_n     = (p_q | q_q) ? p_q : a_q[N-2] & ~b_q[N-2];
        q_n     = (p_q | q_q) ? q_q : ~a_q[N-2] & b_q[N-2];
        ultimo  = (cnt_q == CW'(1)) || (TEMPRANA && (p_n || q_n));
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        mayor_d = mayor_q;
        menor_d = menor_q;
        igual_d = igual_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = COMPARA;
                a_d     = bus.A_resto;
                b_d     = bus.B_resto;
                cnt_d   = CW'(N - 1);
                p_d     = bus.Pinit & ~bus.Qinit;
                q_d     = bus.Qinit & ~bus.Pinit;
            end
            COMPARA: begin
                p_d   = p_n;
                q_d   = q_n;
                a_d   = a_q << 1;
                b_d   = b_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (ultimo) begin
                    state_d = FIN;
                    mayor_d = p_n & ~q_n;
                    menor_d = ~p_n & q_n;
                    igual_d = ~p_n & ~q_n;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            p_q     <= 1'b0;
            q_q     <= 1'b0;
            mayor_q <= 1'b0;
            menor_q <= 1'b0;
            igual_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            mayor_q <= mayor_d;
            menor_q <= menor_d;
            igual_q <= igual_d;
        end
    end
    assign bus.busy  = state_q != IDLE;
    assign bus.done  = state_q == FIN;
    assign bus.mayor = mayor_q;
    assign bus.menor = menor_q;
    assign bus.igual = igual_q;
    assign bus.P     = p_q;
    assign bus.Q     = q_q;
endmodule

// File: tb/tb_comparador_serial_izq_der.sv
// tb_comparador_serial_izq_der: directed vectors with a done-driven scoreboard monitor
module tb_comparador_serial_izq_der;
    localparam int N = 8;
`ifdef COMPARADOR_SALIDA_TEMPRANA_EN
    localparam int L96 = 6;
    localparam int L01 = 1;
`else
    localparam int L96 = 7;
    localparam int L01 = 7;
`endif
    typedef struct {
        int         due;
        logic [4:0] res;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t e;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    comparador_serial_izq_der_if #(.N(N)) bus ();
    comparador_serial_izq_der #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask
    function automatic logic [4:0] outs();
        return {bus.mayor, bus.menor, bus.igual, bus.P, bus.Q};
    endfunction
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.due);
                chk("result_mayor_menor_igual_P_Q", {27'd0, outs()}, {27'd0, e.res});
                chk("busy_at_done", {31'd0, bus.busy}, 32'd1);
            end
        end
    end
    task automatic go(input logic p, input logic q, input logic [6:0] a, input logic [6:0] b,
                      input int lat, input logic [4:0] res, input bit push);
        @(negedge clk); #1;
        bus.start   = 1'b1;
        bus.Pinit   = p;
        bus.Qinit   = q;
        bus.A_resto = a;
        bus.B_resto = b;
        if (push) sb.push_back('{cyc + 1 + lat, res});
        @(negedge clk); #1;
        bus.start   = 1'b0;
        bus.A_resto = ~a;
        bus.B_resto = ~b;
        bus.Pinit   = ~p;
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    endtask
    task automatic wait_done();
        for (int i = 0; i < 30 && sb.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        @(negedge clk); #1;
        chk("idle_after_done", {30'd0, bus.busy, bus.done}, 32'd0);
    endtask
    initial begin
        bus.start   = 1'b0;
        bus.Pinit   = 1'b0;
        bus.Qinit   = 1'b0;
        bus.A_resto = '0;
        bus.B_resto = '0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        chk("reset_outputs", {25'd0, bus.busy, bus.done, outs()}, 32'd0);
        go(1'b0, 1'b0, 7'h25, 7'h25, 7, 5'b00100, 1'b1);
        wait_done();
        go(1'b0, 1'b0, 7'h16, 7'h14, L96, 5'b10010, 1'b1);
        wait_done();
        go(1'b0, 1'b1, 7'h7F, 7'h00, L01, 5'b01001, 1'b1);
        if (L01 > 1) chk("results_hold_while_busy", {29'd0, bus.mayor, bus.menor, bus.igual}, 32'b100);
        wait_done();
        go(1'b1, 1'b1, 7'h00, 7'h00, 7, 5'b00100, 1'b1);
        wait_done();
        go(1'b0, 1'b0, 7'h7F, 7'h7F, 7, 5'b00100, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        bus.start   = 1'b1;
        bus.Pinit   = 1'b1;
        bus.Qinit   = 1'b0;
        bus.A_resto = 7'h00;
        bus.B_resto = 7'h7F;
        @(negedge clk); #1 bus.start = 1'b0;
        wait_done();
        go(1'b0, 1'b0, 7'h16, 7'h14, 0, 5'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
        chk("abort_outputs", {25'd0, bus.busy, bus.done, outs()}, 32'd0);
        repeat (10) begin
            @(negedge clk); #1;
        end
        chk("abort_stays_idle", {25'd0, bus.busy, bus.done, outs()}, 32'd0);
        go(1'b0, 1'b0, 7'h16, 7'h14, L96, 5'b10010, 1'b1);
        wait_done();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", fails);
        $fatal(1, "watchdog");
    end
endmodule
